// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_responder
// Brief    : Instruction-fetch responder with an internal word array, fixed
//            request-to-response latency, fault flags, flush and preload port.
// Revision : 1.0  initial release
// ============================================================================
module imem_fetch_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [ADDR_WIDTH-1:0]          req_addr,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [DATA_WIDTH-1:0]          rsp_instr,
   output logic [1:0]                     rsp_fault,
   input  logic                           flush,
   input  logic                           load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0]          load_data
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_WAIT = 2'd1;
   localparam logic [1:0] c_RESP = 2'd2;

   localparam logic [1:0] c_FAULT_OK       = 2'b00;
   localparam logic [1:0] c_FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] c_FAULT_RANGE    = 2'b10;

   localparam logic [3:0]            c_WAIT_INIT = 4'(LATENCY - 1);
   localparam logic [DATA_WIDTH-1:0] c_NOP       = DATA_WIDTH'(32'h0000_0013);
   localparam bit                    c_SINGLE    = (LATENCY == 1);

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [3:0]            r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [1:0]            r_fault;
   logic [DATA_WIDTH-1:0] r_rsp_instr;
   logic [1:0]            r_rsp_fault;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

   logic                  w_accept;
   logic                  w_out_of_range;
   logic [1:0]            w_req_fault;
   logic [IDX_W-1:0]      w_req_idx;
   logic                  w_enter_resp;
   logic [IDX_W-1:0]      w_rd_idx;
   logic [1:0]            w_rd_fault;

   // Any address bit above the word-index field means the fetch is past the array.
   generate
      if (ADDR_WIDTH > IDX_W + 2) begin : g_range_check
         assign w_out_of_range = |req_addr[ADDR_WIDTH-1:IDX_W+2];
      end else begin : g_range_full
         assign w_out_of_range = 1'b0;
      end
   endgenerate

   assign req_ready = (r_state == c_IDLE) && !flush;
   assign w_accept  = req_valid && req_ready;
   assign w_req_idx = req_addr[IDX_W+1:2];

   always_comb begin
      w_req_fault = c_FAULT_OK;
      if (req_addr[1:0] != 2'b00) begin
         w_req_fault = c_FAULT_MISALIGN;
      end else if (w_out_of_range) begin
         w_req_fault = c_FAULT_RANGE;
      end
   end

   // With single-cycle latency the array is read on the accept edge itself,
   // so the live request is used instead of the latched copy.
   assign w_rd_idx   = (r_state == c_IDLE) ? w_req_idx   : r_idx;
   assign w_rd_fault = (r_state == c_IDLE) ? w_req_fault : r_fault;

   assign w_enter_resp = (c_SINGLE && w_accept) ||
                         ((r_state == c_WAIT) && (r_cnt == 4'd1) && !flush);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_accept) begin
               w_next_state = c_SINGLE ? c_RESP : c_WAIT;
            end
         end
         c_WAIT: begin
            if (flush) begin
               w_next_state = c_IDLE;
            end else if (r_cnt == 4'd1) begin
               w_next_state = c_RESP;
            end
         end
         c_RESP: begin
            if (flush || rsp_ready) begin
               w_next_state = c_IDLE;
            end
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_cnt       <= 4'd0;
         r_idx       <= '0;
         r_fault     <= c_FAULT_OK;
         r_rsp_instr <= '0;
         r_rsp_fault <= c_FAULT_OK;
      end else begin
         r_state <= w_next_state;

         if (w_accept) begin
            r_idx   <= w_req_idx;
            r_fault <= w_req_fault;
            r_cnt   <= c_WAIT_INIT;
         end else if (r_state == c_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end

         // Faulted fetches never touch the array.
         if (w_enter_resp) begin
            r_rsp_fault <= w_rd_fault;
            r_rsp_instr <= (w_rd_fault != c_FAULT_OK) ? c_NOP : r_mem[w_rd_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_en) begin
         r_mem[load_addr] <= load_data;
      end
   end

   assign rsp_valid = (r_state == c_RESP);
   assign rsp_instr = r_rsp_instr;
   assign rsp_fault = r_rsp_fault;

endmodule
`default_nettype wire
